catch_arbiter: RTL
==================

// Module: catch_arbiter
// PURPOSE
// Arbitrates hook-to-object catches among N_OBJ sprite objects (gold/stone) in the miner game.
// Sits between per-object hit detectors and the hook/score logic. Grants at most one object per
// hook extension, sets hook pull speed from object weight, and awards score when the hook returns.
// Tracks which objects are still alive; optional dynamite drops a held object.
// PARAMETERS
// N_OBJ      8    number of arbitrated objects
// VAL_W      8    per-object score value width
// SCORE_W    16   accumulated score width
// INIT_BOMBS 3    dynamite count loaded at reset/new game (4-bit counter)
// PORTS
// Clk          in   1            system clock
// reset        in   1            asynchronous, active-high reset
// new_game     in   1            synchronous clear, same effect as reset
// hook_state   in   3            0=SWING 1=EXTEND 2=RETRACT (others treated as RETRACT)
// obj_hit      in   N_OBJ        per-object hook-tail overlap (opaque pixel), level
// obj_value    in   N_OBJ*VAL_W  packed values, object i at [i*VAL_W +: VAL_W]
// obj_weight   in   N_OBJ*2      packed weight class, 0=light..3=heavy
// explode_req  in   1            dynamite request pulse
// grant        out  N_OBJ        one-hot held object; 0 when none
// catch_valid  out  1            high while an object is held
// pull_speed   out  3            retract pixels/step for the hook
// obj_alive    out  N_OBJ        1 = object still on field
// score        out  SCORE_W      accumulated score
// score_pulse  out  1            1-cycle pulse on score update
// bombs        out  4            remaining dynamite
// explode_ack  out  1            1-cycle pulse on accepted explode
// BEHAVIOUR
// - Reset/new_game: state IDLE, grant=0, catch_valid=0, pull_speed=6, obj_alive=all 1s,
//   score=0, score_pulse=0, bombs=INIT_BOMBS, explode_ack=0. Reset mid-catch discards the
//   catch with no score. new_game has priority over all other inputs.
// - FSM: IDLE -> ARMED when hook_state==EXTEND. ARMED -> IDLE when hook_state==SWING without a hit.
// - ARMED: eligible = obj_hit & obj_alive. If nonzero, the lowest index wins (fixed priority).
//   Next edge: grant=onehot(i), catch_valid=1, pull_speed from weight(i) {0:6, 1:4, 2:2, 3:1},
//   state HOLD. Latency hit->grant is 1 cycle.
// - HOLD: obj_hit ignored; grant is stable. When hook_state==SWING -> AWARD.
// - AWARD (1 cycle): score += value(i), saturating at 2^SCORE_W-1; score_pulse=1;
//   obj_alive[i]=0; grant=0; catch_valid=0; pull_speed=6. Next state IDLE.
// - Hits in IDLE/HOLD/AWARD never change grant. A dead object is never granted.
// - Hit and SWING in the same ARMED cycle: the hit wins -> HOLD, then AWARD next time SWING is sampled.
// - pull_speed is 6 whenever catch_valid=0.
// - score_pulse and explode_ack are never both high in the same cycle.
// CONFIGURATION
// CATCH_EXPLODE_EN defined: in HOLD, explode_req && bombs!=0 -> bombs-1, explode_ack=1,
//   obj_alive[i]=0, grant=0, catch_valid=0, pull_speed=6, state IDLE, no score.
//   explode_req with bombs==0 is ignored. explode_req outside HOLD is ignored.
// CATCH_EXPLODE_EN undefined: explode_req is ignored; bombs is held at INIT_BOMBS; explode_ack is tied 0.
// TESTING
// T1 reset: assert reset -> grant=0, score=0, obj_alive=8'hFF, bombs=3, pull_speed=6.
// T2 single catch: EXTEND, obj_hit=8'h04, weight2=3, value2=50 -> grant=8'h04 next cycle,
//    pull_speed=1; SWING -> score=50, score_pulse 1 cycle, obj_alive=8'hFB.
// T3 simultaneous: ARMED, obj_hit=8'h28 -> grant=8'h08; obj_hit changes to 8'h20 in HOLD -> grant stays 8'h08.
// T4 miss + dead object: re-extend over object 2 (dead), obj_hit=8'h04 -> no grant; SWING -> IDLE, score unchanged.
// T5 saturation: score=16'hFFF0, catch value 8'h40 -> score=16'hFFFF.
// T6 explode (EN defined): HOLD on object 5, explode_req -> explode_ack=1, bombs=2,
//    obj_alive[5]=0, no score_pulse; bombs=0 + explode_req -> ignored.

Source files
------------

// File: rtl/catch_arbiter.sv
// Hook catch arbiter: grants one sprite object per hook extension, sets pull speed, awards score.
// Optional dynamite support (drop a held object) is enabled by defining CATCH_EXPLODE_EN.
module catch_arbiter #(
    parameter int N_OBJ      = 8,
    parameter int VAL_W      = 8,
    parameter int SCORE_W    = 16,
    parameter int INIT_BOMBS = 3
) (
    input  logic                   Clk,
    input  logic                   reset,
    input  logic                   new_game,
    input  logic [2:0]             hook_state,
    input  logic [N_OBJ-1:0]       obj_hit,
    input  logic [N_OBJ*VAL_W-1:0] obj_value,
    input  logic [N_OBJ*2-1:0]     obj_weight,
    input  logic                   explode_req,
    output logic [N_OBJ-1:0]       grant,
    output logic                   catch_valid,
    output logic [2:0]             pull_speed,
    output logic [N_OBJ-1:0]       obj_alive,
    output logic [SCORE_W-1:0]     score,
    output logic                   score_pulse,
    output logic [3:0]             bombs,
    output logic                   explode_ack
);

    localparam int IDX_W = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    localparam logic [2:0] HS_SWING   = 3'd0;
    localparam logic [2:0] HS_EXTEND  = 3'd1;
    localparam logic [2:0] SPEED_REST = 3'd6;
    localparam logic [3:0] BOMBS_INIT = 4'(INIT_BOMBS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_HOLD,
        S_AWARD
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_OBJ-1:0]     grant_q, grant_d;
    logic                 valid_q, valid_d;
    logic [2:0]           speed_q, speed_d;
    logic [N_OBJ-1:0]     alive_q, alive_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 pulse_q, pulse_d;
    logic [3:0]           bombs_q, bombs_d;
    logic                 ack_q, ack_d;

    logic [N_OBJ-1:0]     eligible;
    logic                 hit_found;
    logic [IDX_W-1:0]     hit_idx;
    logic [VAL_W-1:0]     held_val;
    logic [SCORE_W:0]     score_sum;

    function automatic logic [2:0] speed_of(input logic [1:0] w);
        case (w)
            2'd0:    speed_of = 3'd6;
            2'd1:    speed_of = 3'd4;
            2'd2:    speed_of = 3'd2;
            default: speed_of = 3'd1;
        endcase
    endfunction

    assign eligible = obj_hit & alive_q;

    // Fixed priority: scan downward so the lowest set index is the last write.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
        end
    end

    assign held_val  = obj_value[idx_q*VAL_W +: VAL_W];
    assign score_sum = {1'b0, score_q} + {{(SCORE_W + 1 - VAL_W){1'b0}}, held_val};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        valid_d = valid_q;
        speed_d = speed_q;
        alive_d = alive_q;
        score_d = score_q;
        pulse_d = 1'b0;
        bombs_d = bombs_q;
        ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hook_state == HS_EXTEND)
                    state_d = S_ARMED;
            end
            S_ARMED: begin
                // A hit sampled together with SWING still wins the catch.
                if (hit_found) begin
                    state_d          = S_HOLD;
                    idx_d            = hit_idx;
                    grant_d          = '0;
                    grant_d[hit_idx] = 1'b1;
                    valid_d          = 1'b1;
                    speed_d          = speed_of(obj_weight[hit_idx*2 +: 2]);
                end else if (hook_state == HS_SWING) begin
                    state_d = S_IDLE;
                end
            end
            S_HOLD: begin
`ifdef CATCH_EXPLODE_EN
                if (explode_req && bombs_q != 4'd0) begin
                    state_d        = S_IDLE;
                    bombs_d        = bombs_q - 4'd1;
                    ack_d          = 1'b1;
                    alive_d[idx_q] = 1'b0;
                    grant_d        = '0;
                    valid_d        = 1'b0;
                    speed_d        = SPEED_REST;
                end else
`endif
                if (hook_state == HS_SWING) begin
                    state_d        = S_AWARD;
                    score_d        = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
                    pulse_d        = 1'b1;
                    alive_d[idx_q] = 1'b0;
                    grant_d        = '0;
                    valid_d        = 1'b0;
                    speed_d        = SPEED_REST;
                end
            end
            S_AWARD: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (new_game) begin
            state_d = S_IDLE;
            idx_d   = '0;
            grant_d = '0;
            valid_d = 1'b0;
            speed_d = SPEED_REST;
            alive_d = '1;
            score_d = '0;
            pulse_d = 1'b0;
            bombs_d = BOMBS_INIT;
            ack_d   = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            speed_q <= SPEED_REST;
            alive_q <= '1;
            score_q <= '0;
            pulse_q <= 1'b0;
            bombs_q <= BOMBS_INIT;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            speed_q <= speed_d;
            alive_q <= alive_d;
            score_q <= score_d;
            pulse_q <= pulse_d;
            bombs_q <= bombs_d;
            ack_q   <= ack_d;
        end
    end

`ifndef CATCH_EXPLODE_EN
    logic unused_explode;
    assign unused_explode = explode_req;
`endif

    assign grant       = grant_q;
    assign catch_valid = valid_q;
    assign pull_speed  = speed_q;
    assign obj_alive   = alive_q;
    assign score       = score_q;
    assign score_pulse = pulse_q;
    assign bombs       = bombs_q;
    assign explode_ack = ack_q;

endmodule
